// File: rtl/instr_cache_ctrl_pkg.sv
// instr_cache_ctrl_pkg: shared types and constants for the instruction cache controller
package instr_cache_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_MEM_READ, ST_UPDATE} state_t;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int WORD_BITS       = 32;
    localparam int WORDS_PER_LINE  = 4;
    localparam int LINE_BITS       = WORD_BITS * WORDS_PER_LINE;
    localparam int WORD_SEL_BITS   = 2;
    localparam int OFFSET_BITS     = 4;
    localparam int BLOCK_ADDR_BITS = 32 - OFFSET_BITS;

    function automatic logic [WORD_BITS-1:0] select_word(input logic [LINE_BITS-1:0] line,
                                                         input logic [WORD_SEL_BITS-1:0] sel);
        return line[WORD_BITS*sel +: WORD_BITS];
    endfunction
endpackage

// File: rtl/instr_cache_line_store.sv
// instr_cache_line_store: valid/tag/data arrays, one write port and one combinational read port
module instr_cache_line_store
    import instr_cache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = BLOCK_ADDR_BITS - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] w_index,
    input  logic [TAG_BITS-1:0]   w_tag,
    input  logic [LINE_BITS-1:0]  w_data,
    input  logic [INDEX_BITS-1:0] r_index,
    output logic                  r_valid,
    output logic [TAG_BITS-1:0]   r_tag,
    output logic [LINE_BITS-1:0]  r_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid;
    logic [TAG_BITS-1:0]  tags  [LINES];
    logic [LINE_BITS-1:0] lines [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid <= '0;
        else if (we)
            valid[w_index] <= 1'b1;
    end

    // tag and data need no reset: a cleared valid bit masks them
    always_ff @(posedge clk) begin
        if (we) begin
            tags[w_index]  <= w_tag;
            lines[w_index] <= w_data;
        end
    end

    assign r_valid = valid[r_index];
    assign r_tag   = tags[r_index];
    assign r_data  = lines[r_index];
endmodule

// File: rtl/instr_cache_ctrl.sv
// instr_cache_ctrl: direct-mapped instruction cache with zero-wait hits and a three-state refill FSM
module instr_cache_ctrl
    import instr_cache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [31:0]                ADDRESS,
    input  logic                       READ,
    output logic [31:0]                INSTRUCTION,
    output logic                       BUSYWAIT,
    output logic [BLOCK_ADDR_BITS-1:0] MEM_ADDRESS,
    output logic                       MEM_READ,
    input  logic [LINE_BITS-1:0]       MEM_READDATA,
    input  logic                       MEM_BUSYWAIT,
    output logic [31:0]                HIT_COUNT,
    output logic [31:0]                MISS_COUNT
);
    localparam int TAG_BITS = BLOCK_ADDR_BITS - INDEX_BITS;

    state_t                     state;
    logic [BLOCK_ADDR_BITS-1:0] blk_addr;
    logic [LINE_BITS-1:0]       fill_buf;
    logic                       r_valid;
    logic [TAG_BITS-1:0]        r_tag;
    logic [LINE_BITS-1:0]       r_data;
    logic                       hit;
    logic                       unused_byte_offset;

    assign unused_byte_offset = ^ADDRESS[1:0];

    instr_cache_line_store #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_store (
        .clk    (CLK),
        .rst_n  (RESET),
        .we     (state == ST_UPDATE),
        .w_index(blk_addr[INDEX_BITS-1:0]),
        .w_tag  (blk_addr[BLOCK_ADDR_BITS-1:INDEX_BITS]),
        .w_data (fill_buf),
        .r_index(ADDRESS[OFFSET_BITS +: INDEX_BITS]),
        .r_valid(r_valid),
        .r_tag  (r_tag),
        .r_data (r_data)
    );

    assign hit         = READ && (state == ST_IDLE) && r_valid && (r_tag == ADDRESS[31:OFFSET_BITS+INDEX_BITS]);
    assign INSTRUCTION = hit ? select_word(r_data, ADDRESS[OFFSET_BITS-1:2]) : NOP;
    assign BUSYWAIT    = (state != ST_IDLE) || (READ && !hit);
    assign MEM_ADDRESS = blk_addr;

    // the refill works only from blk_addr, so ADDRESS may wander during a fill
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            blk_addr   <= '0;
            fill_buf   <= '0;
            MEM_READ   <= 1'b0;
            HIT_COUNT  <= '0;
            MISS_COUNT <= '0;
        end else begin
            HIT_COUNT <= HIT_COUNT + 32'(hit);
            case (state)
                ST_IDLE: if (READ && !hit) begin
                    state      <= ST_MEM_READ;
                    blk_addr   <= ADDRESS[31:OFFSET_BITS];
                    MEM_READ   <= 1'b1;
                    MISS_COUNT <= MISS_COUNT + 32'd1;
                end
                ST_MEM_READ: if (!MEM_BUSYWAIT) begin
                    state    <= ST_UPDATE;
                    fill_buf <= MEM_READDATA;
                    MEM_READ <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_cache_ctrl.sv
// tb_instr_cache_ctrl: directed and randomized checks of the cache against a behavioural model
module tb_instr_cache_ctrl;
    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [31:0]  ADDRESS = '0;
    logic         READ = 1'b0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic [27:0]  MEM_ADDRESS;
    logic         MEM_READ;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT = 1'b0;
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;

    int n_tests = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    instr_cache_ctrl dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ADDRESS     (ADDRESS),
        .READ        (READ),
        .INSTRUCTION (INSTRUCTION),
        .BUSYWAIT    (BUSYWAIT),
        .MEM_ADDRESS (MEM_ADDRESS),
        .MEM_READ    (MEM_READ),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT),
        .HIT_COUNT   (HIT_COUNT),
        .MISS_COUNT  (MISS_COUNT)
    );

    // instruction memory: each word's content is a fixed function of its address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[31:2], 2'b00};
    endfunction

    assign MEM_READDATA = {mem_word({MEM_ADDRESS, 4'hC}), mem_word({MEM_ADDRESS, 4'h8}),
                           mem_word({MEM_ADDRESS, 4'h4}), mem_word({MEM_ADDRESS, 4'h0})};

    // memory is busy for lat cycles of a request, then ready for one
    int lat = 4;
    int mcnt = 0;
    bit rd_prev = 1'b0;
    always @(posedge CLK) begin
        #1;
        mcnt = (MEM_READ && rd_prev) ? mcnt + 1 : 0;
        rd_prev = MEM_READ;
        MEM_BUSYWAIT = MEM_READ && (mcnt < lat);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: which blocks are resident, plus a countdown of the outstanding fill
    bit [7:0]    m_valid = '0;
    logic [24:0] m_tag [8];
    int          fill_left = 0;
    logic [27:0] fill_blk = '0;
    logic [31:0] m_hits = '0;
    logic [31:0] m_misses = '0;
    logic        s_read = 1'b0;
    logic [31:0] s_addr = '0;

    function automatic bit m_hit(input logic rd, input logic [31:0] a);
        return rd && fill_left == 0 && m_valid[a[6:4]] && m_tag[a[6:4]] == a[31:7];
    endfunction

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_valid = '0;
            fill_left = 0;
            m_hits = '0;
            m_misses = '0;
        end else if (fill_left > 0) begin
            fill_left--;
            if (fill_left == 0) begin
                m_valid[fill_blk[2:0]] = 1'b1;
                m_tag[fill_blk[2:0]] = fill_blk[27:3];
            end
        end else if (m_hit(s_read, s_addr)) begin
            m_hits++;
        end else if (s_read) begin
            m_misses++;
            fill_blk = s_addr[31:4];
            fill_left = lat + 2;
        end
    end

    always @(negedge CLK) begin
        bit h;
        s_read = READ;
        s_addr = ADDRESS;
        if (RESET) begin
            h = m_hit(READ, ADDRESS);
            chk("busywait", 32'(BUSYWAIT), 32'(fill_left > 0 || (READ && !h)));
            chk("instruction", INSTRUCTION, h ? mem_word(ADDRESS) : 32'h0000_0013);
            chk("mem_read", 32'(MEM_READ), 32'(fill_left > 1));
            if (fill_left > 1) chk("mem_address", 32'(MEM_ADDRESS), 32'(fill_blk));
            chk("hit_count", HIT_COUNT, m_hits);
            chk("miss_count", MISS_COUNT, m_misses);
        end
    end

    task automatic drive(input logic rd, input logic [31:0] a);
        @(posedge CLK);
        #1;
        READ = rd;
        ADDRESS = a;
    endtask

    // counts BUSYWAIT cycles of the fetch just driven, checking the block requested
    task automatic wait_idle(input string name, input logic [27:0] eblk, output int nb);
        nb = 0;
        @(negedge CLK);
        while (BUSYWAIT && nb < 100) begin
            nb++;
            if (MEM_READ) chk({name, "_mem_addr"}, 32'(MEM_ADDRESS), 32'(eblk));
            @(negedge CLK);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nb;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        chk("rst_hit_count", HIT_COUNT, 0);
        chk("rst_miss_count", MISS_COUNT, 0);
        chk("rst_mem_read", 32'(MEM_READ), 0);
        chk("rst_mem_address", 32'(MEM_ADDRESS), 0);
        chk("rst_busywait", 32'(BUSYWAIT), 0);

        drive(1'b1, 32'h0);
        wait_idle("cold", 28'h0, nb);
        chk("cold_penalty", nb, 7);
        chk("cold_word0", INSTRUCTION, 32'hC0DE_0000);
        chk("cold_miss_count", MISS_COUNT, 1);
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 32'(i * 4));
            @(negedge CLK);
            chk("hit_word", INSTRUCTION, 32'hC0DE_0000 | 32'(i * 4));
            chk("hit_busywait", 32'(BUSYWAIT), 0);
            chk("hit_mem_read", 32'(MEM_READ), 0);
        end
        drive(1'b0, 32'h0);
        @(negedge CLK);
        chk("hit_count_4", HIT_COUNT, 4);

        drive(1'b1, 32'h80);
        wait_idle("conflict", 28'h8, nb);
        chk("conflict_penalty", nb, 7);
        chk("conflict_word", INSTRUCTION, 32'hC0DE_0080);
        drive(1'b1, 32'h0);
        wait_idle("refetch", 28'h0, nb);
        chk("refetch_penalty", nb, 7);
        chk("refetch_word", INSTRUCTION, 32'hC0DE_0000);
        chk("conflict_miss_count", MISS_COUNT, 3);

        drive(1'b1, 32'h100);
        @(posedge CLK);
        @(posedge CLK);
        #3 RESET = 1'b0;
        #1;
        chk("abort_mem_read", 32'(MEM_READ), 0);
        chk("abort_busywait", 32'(BUSYWAIT), 1);
        chk("abort_miss_count", MISS_COUNT, 0);
        chk("abort_hit_count", HIT_COUNT, 0);
        @(posedge CLK);
        #1 RESET = 1'b1;
        READ = 1'b0;
        drive(1'b1, 32'h0);
        wait_idle("after_abort", 28'h0, nb);
        chk("after_abort_penalty", nb, 7);
        chk("after_abort_miss_count", MISS_COUNT, 1);

        drive(1'b1, 32'h40);
        repeat (5) begin
            @(posedge CLK);
            #1 ADDRESS = $urandom & 32'h0000_FFF0;
        end
        @(posedge CLK);
        #1 ADDRESS = 32'h40;
        @(negedge CLK);
        chk("toggle_update_busy", 32'(BUSYWAIT), 1);
        @(negedge CLK);
        chk("toggle_word", INSTRUCTION, 32'hC0DE_0040);
        chk("toggle_busywait", 32'(BUSYWAIT), 0);

        for (int seg = 0; seg < 4; seg++) begin
            drive(1'b0, 32'h0);
            repeat (12) @(posedge CLK);
            #1 lat = $urandom_range(0, 5);
            repeat (300) begin
                @(posedge CLK);
                #1;
                if ($urandom_range(0, 149) == 0) begin
                    #2 RESET = 1'b0;
                    @(posedge CLK);
                    #1 RESET = 1'b1;
                end
                READ = $urandom_range(0, 3) != 0;
                ADDRESS = ($urandom & 32'h0000_30FF) | ($urandom_range(0, 7) == 0 ? 32'h8000_0000 : 32'h0);
            end
        end
        drive(1'b0, 32'h0);
        repeat (12) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_cache_ctrl.md
INSTR_CACHE_CTRL -- requirements
Module: instr_cache_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named CLK and RESET.
REQ-002 Parameter INDEX_BITS SHALL default to 3 and set the number of lines (2**INDEX_BITS, direct-mapped).
REQ-003 Port CLK SHALL be: input, 1 bit, rising-edge clock.
REQ-004 Port RESET SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port ADDRESS SHALL be: input, 32 bits, fetch PC from the fetch stage.
REQ-006 Port READ SHALL be: input, 1 bit, fetch request.
REQ-007 Port INSTRUCTION SHALL be: output, 32 bits, fetched word.
REQ-008 Port BUSYWAIT SHALL be: output, 1 bit, stall to the fetch stage and to if_id_reg.
REQ-009 Port MEM_ADDRESS SHALL be: output, 28 bits, block address (ADDRESS[31:4]) to instruction memory.
REQ-010 Port MEM_READ SHALL be: output, 1 bit, block read request.
REQ-011 Port MEM_READDATA SHALL be: input, 128 bits, block data; word 0 is in bits [31:0].
REQ-012 Port MEM_BUSYWAIT SHALL be: input, 1 bit, memory busy.
REQ-013 Ports HIT_COUNT and MISS_COUNT SHALL be: outputs, 32 bits each, performance counters.

Function
REQ-014 Address split: [1:0] ignored; [3:2] word select; [3+INDEX_BITS:4] index; [31:4+INDEX_BITS] tag.
REQ-015 HIT SHALL be asserted combinationally when READ is high, the state is IDLE, the indexed line is valid and its stored tag equals the address tag.
REQ-016 On a hit, INSTRUCTION SHALL be the selected word in the same cycle (zero-wait), and BUSYWAIT SHALL be 0.
REQ-017 Whenever HIT is low, INSTRUCTION SHALL be 32'h0000_0013 (NOP).
REQ-018 BUSYWAIT SHALL be 1 when READ is high and HIT is low, and SHALL be 1 in any state other than IDLE.
REQ-019 The FSM SHALL have three states: IDLE, MEM_READ and UPDATE.
REQ-020 IDLE -> MEM_READ on a clock edge with READ high and HIT low; the miss address [31:4] SHALL be latched at that edge.
REQ-021 In MEM_READ, MEM_READ SHALL be 1 and MEM_ADDRESS SHALL equal the latched block address; in all other states MEM_READ SHALL be 0.
REQ-022 MEM_READ -> UPDATE on an edge with MEM_BUSYWAIT low; MEM_READDATA SHALL be captured into a fill buffer at that edge.
REQ-023 UPDATE -> IDLE unconditionally; at that edge the fill buffer, latched tag and valid=1 SHALL be written to the latched index.
REQ-024 Miss penalty SHALL be (memory busy cycles + 3) cycles of BUSYWAIT; the re-compare in IDLE then hits.
REQ-025 After the miss edge, fill SHALL use only the latched address; ADDRESS changes during a fill SHALL NOT corrupt the line.
REQ-026 READ low in IDLE SHALL start no fill and change no counter.
REQ-027 HIT_COUNT SHALL increment on each edge with HIT high; MISS_COUNT SHALL increment on each IDLE->MEM_READ transition; both SHALL wrap modulo 2**32.
REQ-028 A same-index, different-tag miss SHALL overwrite the line; no other line SHALL be modified.

Reset
REQ-029 Asserting RESET low SHALL immediately set the state to IDLE, clear all valid bits, set MEM_READ=0 and MEM_ADDRESS=0, and clear HIT_COUNT, MISS_COUNT and the latched address.
REQ-030 A reset during MEM_READ or UPDATE SHALL abort the fill without writing the line; MEM_READ SHALL drop asynchronously.
REQ-031 Tag and data arrays need not be reset.

Structure
REQ-032 A shared package SHALL hold the state encoding, the NOP constant, and the block/word-offset widths (4 words/line, 128-bit line).
REQ-033 One sub-module, instr_cache_line_store, SHALL hold the valid, tag and data arrays, with one write port and one combinational read port.

Verification
REQ-034 Cold miss at 0x0000_0000 with memory busy for 4 cycles, data {W3,W2,W1,W0} -> MEM_ADDRESS=0, BUSYWAIT high 7 cycles, then INSTRUCTION=W0; MISS_COUNT=1.
REQ-035 Then fetch 0x4, 0x8, 0xC -> zero-wait hits returning W1..W3; HIT_COUNT=4; MEM_READ never asserted.
REQ-036 Fetch 0x80 (index 0, new tag), then 0x0 -> two misses, MEM_ADDRESS 0x8 then 0x0; MISS_COUNT increases by 2.
REQ-037 RESET low during MEM_READ -> MEM_READ=0 at once, state IDLE; next fetch of 0x0 misses again.
REQ-038 ADDRESS toggled during a fill of 0x40 -> line 4 holds 0x40's block; fetch 0x40 then hits.
